dma_rd_sched: RTL and testbench
===============================

DMA_RD_SCHED -- requirements
Module: dma_rd_sched

Interface
REQ-001 Parameter NUM_TAGS, default 4, number of outstanding read tags, legal range 1..8.
REQ-002 Parameter TIMEOUT_CYC, default 50000, completion-timeout limit in clk_i cycles.
REQ-003 clk_i  in  1  sole clock, 250 MHz PCIe user clock.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  one-cycle pulse that starts a transfer.
REQ-006 sys_addr_i  in  32  host byte address; 128-byte aligned.
REQ-007 len_i  in  32  transfer length in bytes; multiple of 128.
REQ-008 busy_o  out  1  transfer in progress.
REQ-009 done_o  out  1  one-cycle pulse when the transfer ends.
REQ-010 err_o  out  1  sticky error flag; cleared by an accepted start_i.
REQ-011 rd_req_o  out  1  memory read request to the Tx engine.
REQ-012 rd_req_ack_i  in  1  Tx engine has sent the request.
REQ-013 rd_addr_o  out  32  request byte address.
REQ-014 rd_len_o  out  10  request length in DW; constant 32.
REQ-015 rd_tag_o  out  8  request tag, value 0..NUM_TAGS-1.
REQ-016 cpl_valid_i  in  1  Rx engine received a CplD header.
REQ-017 cpl_tag_i  in  8  tag of that CplD.
REQ-018 cpl_len_i  in  10  DW length of that CplD.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT_ACK, DRAIN.
REQ-020 IDLE: an accepted start_i latches address and length; next state is ISSUE, or DRAIN when len_i=0. start_i is ignored when busy_o=1.
REQ-021 rd_req_o SHALL assert in the cycle after start_i when a tag is free.
REQ-022 ISSUE: with at least one free tag and remaining length >0, assert rd_req_o with the lowest free tag and go to WAIT_ACK.
- With no free tag, hold in ISSUE with rd_req_o=0.
REQ-023 WAIT_ACK: rd_addr_o, rd_len_o and rd_tag_o are stable while rd_req_o=1.
- On rd_req_ack_i: deassert rd_req_o; mark the tag busy with an expected count of 32 DW; address +=128; remaining -=128.
- Next state is ISSUE while remaining >0, otherwise DRAIN.
- rd_req_o stays low for at least one cycle between requests.
REQ-024 Completions: each cpl_valid_i adds cpl_len_i to the received count of cpl_tag_i.
- When the received count reaches 32, that tag is freed; the freed tag is allocatable the following cycle.
- Split completions (for example 2x16 DW) are legal.
REQ-025 A completion on a tag that is not busy, or one that overflows 32 DW, sets err_o and is otherwise ignored.
REQ-026 DRAIN: when all tags are free, pulse done_o, clear busy_o, return to IDLE.
REQ-027 A completion and an allocation of different tags in the same cycle are both honoured; the same tag cannot be freed and allocated in one cycle.
REQ-028 Address arithmetic is 32-bit modulo; with 128-byte aligned inputs no request crosses a 4 KB boundary.
REQ-029 busy_o is 1 in every state except IDLE.

Reset
REQ-030 rst_i SHALL force IDLE and all tags free; busy_o, done_o, err_o and rd_req_o = 0; rd_addr_o and rd_tag_o = 0; rd_len_o = 32; all counters = 0.
REQ-031 rst_i asserted mid-transfer abandons outstanding tags; completions arriving after reset are treated per REQ-025.

Configuration
REQ-032 Macro DMA_RD_TIMEOUT_EN defined: a counter clears on every cpl_valid_i and increments while any tag is busy.
- On reaching TIMEOUT_CYC: set err_o, free all tags, stop issuing, pulse done_o, return to IDLE.
REQ-033 Macro DMA_RD_TIMEOUT_EN undefined: no counter is built, and no timeout abort occurs.

Structure
REQ-034 Package dma_rd_pkg SHALL hold MRRS_DW=32, MRRS_BYTES=128, TAG_W=8, and the FSM state enum.
REQ-035 Sub-module dma_tag_pool SHALL hold:
- the free bitmap;
- the per-tag DW counters;
- the lowest-free priority encoder;
- the error detect for REQ-025.

Verification
REQ-036 start_i, addr=0x1000, len=512, immediate acks, full 32-DW completions -> 4 requests: addr 0x1000/0x1080/0x1100/0x1180, tags 0/1/2/3; done_o one cycle after the last completion.
REQ-037 len=1024 with NUM_TAGS=4 and completions withheld -> exactly 4 requests, then a stall; completing tag 2 -> the next request uses tag 2.
REQ-038 Tag 0 completed as two CplD of 16 DW -> freed only after the second; one 40-DW CplD -> err_o=1.
REQ-039 len=0 -> no rd_req_o; done_o one cycle after start_i; start_i while busy has no effect.
REQ-040 With DMA_RD_TIMEOUT_EN and TIMEOUT_CYC=100, no completions -> err_o=1 and done_o at cycle 100 after the last ack; rst_i mid-transfer -> all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/dma_rd_pkg.sv
// Shared constants and FSM state encoding for the DMA read scheduler.
package dma_rd_pkg;

  localparam int unsigned MRRS_DW    = 32;
  localparam int unsigned MRRS_BYTES = 128;
  localparam int unsigned TAG_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DRAIN
  } state_t;

endpackage

// File: rtl/dma_tag_pool.sv
// Read-tag pool: free bitmap, per-tag received-DW counters, lowest-free
// tag encoder and completion error detection.
module dma_tag_pool
  import dma_rd_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic             flush_i,
  input  logic             cpl_valid_i,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [9:0]       cpl_len_i,
  output logic             free_avail_o,
  output logic [TAG_W-1:0] free_tag_o,
  output logic             any_busy_o,
  output logic             all_free_nxt_o,
  output logic             cpl_err_o
);

  localparam int unsigned CNT_W = $clog2(MRRS_DW + 1);

  logic [NUM_TAGS-1:0] busy_q;
  logic [NUM_TAGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_q   [NUM_TAGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_TAGS];
  logic [10:0]         sum;
  logic                tag_known;
  logic                found;

  // Next-state of bitmap and counters: completions, allocation, then flush.
  always_comb begin
    busy_nxt  = busy_q;
    cpl_err_o = 1'b0;
    tag_known = 1'b0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (cpl_valid_i && (cpl_tag_i == TAG_W'(i))) begin
        tag_known = 1'b1;
        sum = 11'(cnt_q[i]) + 11'(cpl_len_i);
        if (!busy_q[i] || (sum > 11'(MRRS_DW))) begin
          cpl_err_o = 1'b1;
        end else if (sum == 11'(MRRS_DW)) begin
          busy_nxt[i] = 1'b0;
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = CNT_W'(sum);
        end
      end
    end
    if (cpl_valid_i && !tag_known) begin
      cpl_err_o = 1'b1;
    end
    // Allocation picks from busy_q, so a tag freed this cycle is never re-allocated in it.
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (alloc_i && (alloc_tag_i == TAG_W'(i))) begin
        busy_nxt[i] = 1'b1;
      end
    end
    if (flush_i) begin
      busy_nxt = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        cnt_nxt[i] = '0;
      end
    end
  end

  // Register bitmap and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_nxt;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  // Lowest-index free tag.
  always_comb begin
    free_tag_o = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!found && !busy_q[i]) begin
        free_tag_o = TAG_W'(i);
        found      = 1'b1;
      end
    end
  end

  assign free_avail_o   = ~&busy_q;
  assign any_busy_o     = |busy_q;
  assign all_free_nxt_o = ~|busy_nxt;

endmodule

// File: rtl/dma_rd_sched.sv
// DMA read scheduler: splits a host read into 128-byte MRd requests over a
// pool of tags and tracks completions until the transfer drains.
// Optional build macro: DMA_RD_TIMEOUT_EN enables the completion timeout.
module dma_rd_sched
  import dma_rd_pkg::*;
#(
  parameter int unsigned NUM_TAGS    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] sys_addr_i,
  input  logic [31:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        rd_req_o,
  input  logic        rd_req_ack_i,
  output logic [31:0] rd_addr_o,
  output logic [9:0]  rd_len_o,
  output logic [7:0]  rd_tag_o,
  input  logic        cpl_valid_i,
  input  logic [7:0]  cpl_tag_i,
  input  logic [9:0]  cpl_len_i
);

  state_t             state_q;
  logic [31:0]        remain_q;
  logic               alloc;
  logic               tmo_hit;
  logic               free_avail;
  logic [TAG_W-1:0]   free_tag;
  logic               any_busy;
  logic               all_free_nxt;
  logic               cpl_err;

  assign alloc    = (state_q == WAIT_ACK) && rd_req_o && rd_req_ack_i;
  assign rd_len_o = 10'(MRRS_DW);

  dma_tag_pool #(
    .NUM_TAGS(NUM_TAGS)
  ) u_pool (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_i        (alloc),
    .alloc_tag_i    (rd_tag_o),
    .flush_i        (tmo_hit),
    .cpl_valid_i    (cpl_valid_i),
    .cpl_tag_i      (cpl_tag_i),
    .cpl_len_i      (cpl_len_i),
    .free_avail_o   (free_avail),
    .free_tag_o     (free_tag),
    .any_busy_o     (any_busy),
    .all_free_nxt_o (all_free_nxt),
    .cpl_err_o      (cpl_err)
  );

`ifdef DMA_RD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  // Completion watchdog: restarts on every completion, runs while tags are outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i || cpl_valid_i || !any_busy) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = any_busy && !cpl_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC ^ any_busy;
  assign tmo_hit        = 1'b0;
`endif

  // Transfer FSM with registered request and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rd_req_o  <= 1'b0;
      rd_addr_o <= '0;
      rd_tag_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (tmo_hit) begin
        busy_o   <= 1'b0;
        done_o   <= 1'b1;
        rd_req_o <= 1'b0;
        state_q  <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              err_o     <= 1'b0;
              rd_addr_o <= sys_addr_i;
              remain_q  <= len_i;
              // The pool is always empty in IDLE, so a zero-length DRAIN completes at once.
              // A non-zero start issues the first request directly to meet next-cycle rd_req_o.
              if (len_i == '0) begin
                done_o <= 1'b1;
              end else if (free_avail) begin
                busy_o   <= 1'b1;
                rd_req_o <= 1'b1;
                rd_tag_o <= free_tag;
                state_q  <= WAIT_ACK;
              end else begin
                busy_o  <= 1'b1;
                state_q <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (free_avail) begin
              rd_req_o <= 1'b1;
              rd_tag_o <= free_tag;
              state_q  <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (rd_req_ack_i) begin
              rd_req_o  <= 1'b0;
              rd_addr_o <= rd_addr_o + 32'(MRRS_BYTES);
              if (remain_q > 32'(MRRS_BYTES)) begin
                remain_q <= remain_q - 32'(MRRS_BYTES);
                state_q  <= ISSUE;
              end else begin
                remain_q <= '0;
                state_q  <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (all_free_nxt) begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      if (cpl_err || tmo_hit) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_rd_sched.sv
// Directed self-checking bench for dma_rd_sched with a request scoreboard.
module tb_dma_rd_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] sys_addr_i;
  logic [31:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        rd_req_o;
  logic        rd_req_ack_i;
  logic [31:0] rd_addr_o;
  logic [9:0]  rd_len_o;
  logic [7:0]  rd_tag_o;
  logic        cpl_valid_i;
  logic [7:0]  cpl_tag_i;
  logic [9:0]  cpl_len_i;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  tag;
  } req_t;

  req_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  dma_rd_sched #(
    .NUM_TAGS   (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .sys_addr_i  (sys_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rd_req_o    (rd_req_o),
    .rd_req_ack_i(rd_req_ack_i),
    .rd_addr_o   (rd_addr_o),
    .rd_len_o    (rd_len_o),
    .rd_tag_o    (rd_tag_o),
    .cpl_valid_i (cpl_valid_i),
    .cpl_tag_i   (cpl_tag_i),
    .cpl_len_i   (cpl_len_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [7:0] t);
    req_t r;
    r.addr = a;
    r.tag  = t;
    exp_q.push_back(r);
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] l);
    start_i    = 1'b1;
    sys_addr_i = a;
    len_i      = l;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic cpl(input logic [7:0] t, input logic [9:0] l);
    cpl_valid_i = 1'b1;
    cpl_tag_i   = t;
    cpl_len_i   = l;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
  endtask

  // Wait (bounded) for each request, compare it against the scoreboard, then ack it.
  task automatic serve(input int n);
    req_t        r;
    logic [31:0] a;
    logic [7:0]  t;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!rd_req_o && w < 50) begin
        @(negedge clk_i);
        w++;
      end
      chk("req_seen", rd_req_o, 1);
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("req_addr", rd_addr_o, r.addr);
        chk("req_tag", rd_tag_o, r.tag);
      end
      chk("req_len", rd_len_o, 32);
      a = rd_addr_o;
      t = rd_tag_o;
      @(negedge clk_i);
      chk("req_stable", {rd_req_o, rd_tag_o, rd_addr_o[22:0]}, {1'b1, t, a[22:0]});
      rd_req_ack_i = 1'b1;
      @(negedge clk_i);
      rd_req_ack_i = 1'b0;
      chk("req_gap", rd_req_o, 0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_done"}, done_o, 0);
    chk({pfx, "_err"}, err_o, 0);
    chk({pfx, "_req"}, rd_req_o, 0);
    chk({pfx, "_addr"}, rd_addr_o, 0);
    chk({pfx, "_tag"}, rd_tag_o, 0);
    chk({pfx, "_len"}, rd_len_o, 32);
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    sys_addr_i   = '0;
    len_i        = '0;
    rd_req_ack_i = 1'b0;
    cpl_valid_i  = 1'b0;
    cpl_tag_i    = '0;
    cpl_len_i    = '0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    // 512 bytes at 0x1000, immediate acks, full completions.
    for (int i = 0; i < 4; i++) push_req(32'h1000 + 32'(i) * 128, 8'(i));
    do_start(32'h1000, 512);
    chk("req_next_cycle", rd_req_o, 1);
    chk("busy_run", busy_o, 1);
    serve(4);
    chk("busy_drain", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      cpl(8'(i), 10'd32);
      chk("done_early", done_o, 0);
    end
    cpl(8'd3, 10'd32);
    chk("done_last_cpl", done_o, 1);
    chk("busy_after_done", busy_o, 0);
    @(negedge clk_i);
    chk("done_pulse", done_o, 0);

    // 1024 bytes with completions withheld: stall after four tags.
    for (int i = 0; i < 4; i++) push_req(32'h2000 + 32'(i) * 128, 8'(i));
    do_start(32'h2000, 1024);
    serve(4);
    repeat (5) @(negedge clk_i);
    chk("stall_no_req", rd_req_o, 0);
    push_req(32'h2200, 8'd2);
    cpl(8'd2, 10'd32);
    serve(1);
    push_req(32'h2280, 8'd0);
    cpl(8'd0, 10'd32);
    serve(1);
    push_req(32'h2300, 8'd1);
    cpl(8'd1, 10'd32);
    serve(1);
    push_req(32'h2380, 8'd3);
    cpl(8'd3, 10'd32);
    serve(1);

    // Split completion on tag 0 frees it only after the second half.
    cpl(8'd0, 10'd16);
    cpl(8'd2, 10'd32);
    cpl(8'd1, 10'd32);
    cpl(8'd3, 10'd32);
    chk("split_half_busy", {busy_o, done_o}, 2'b10);
    cpl(8'd0, 10'd16);
    chk("split_done", done_o, 1);
    chk("split_no_err", err_o, 0);

    // Address wrap at 2^32 and an overflowing 40-DW completion.
    push_req(32'hFFFF_FF80, 8'd0);
    push_req(32'h0000_0000, 8'd1);
    do_start(32'hFFFF_FF80, 256);
    serve(2);
    cpl(8'd0, 10'd40);
    chk("ovf_err", err_o, 1);
    chk("ovf_ignored", busy_o, 1);
    cpl(8'd0, 10'd32);
    cpl(8'd1, 10'd32);
    chk("ovf_done", done_o, 1);
    chk("err_sticky", err_o, 1);

    // Zero-length transfer.
    do_start(32'h0, 0);
    chk("zero_done", done_o, 1);
    chk("zero_no_req", rd_req_o, 0);
    chk("zero_err_clr", err_o, 0);
    @(negedge clk_i);
    chk("zero_done_pulse", done_o, 0);

    // start_i while busy is ignored.
    push_req(32'h3000, 8'd0);
    do_start(32'h3000, 128);
    do_start(32'h5000, 512);
    serve(1);
    cpl(8'd0, 10'd32);
    chk("busy_start_done", done_o, 1);
    repeat (5) @(negedge clk_i);
    chk("busy_start_ignored", {busy_o, rd_req_o}, 2'b00);

    // Completion on a free tag.
    cpl(8'd1, 10'd32);
    chk("stray_err", err_o, 1);

    // Reset mid-transfer, then a completion for an abandoned tag.
    push_req(32'h4000, 8'd0);
    do_start(32'h4000, 512);
    serve(1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_outputs("midrst");
    cpl(8'd0, 10'd32);
    chk("abandoned_err", err_o, 1);

`ifdef DMA_RD_TIMEOUT_EN
    begin
      int cyc = 0;
      push_req(32'h6000, 8'd0);
      do_start(32'h6000, 128);
      serve(1);
      while (!done_o && cyc < 200) begin
        @(negedge clk_i);
        cyc++;
      end
      chk("tmo_cycle", cyc, 100);
      chk("tmo_err", err_o, 1);
      chk("tmo_idle", {busy_o, rd_req_o}, 2'b00);
    end
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
